// File: rtl/fetch_queue_top.sv
// fetch_queue_top
//   Fetch front end with a DEPTH-entry prefetch queue. It generates the fetch
//   PC and captures the instruction-memory read data together with PC and
//   PC+4. The oldest entry is presented to decode over a valid/ready
//   handshake. An execute-stage redirect flushes the queue and reloads the PC.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   en_fetch   fetch enable; 0 holds the PC and blocks pushes
//   PCF        fetch PC to instruction memory
//   InstrF     instruction-memory read data for PCF (same cycle)
//   RedirectE  taken branch/jump from execute
//   TargetE    redirect target (low two bits forced to zero)
//   InstrD     head instruction (NOP_INSTR while empty)
//   PCD        head PC (last popped PC while empty)
//   PCPlus4D   head PC+4 (last popped PC+4 while empty)
//   ValidD     head entry valid
//   ReadyD     decode accepts the head
//   Count      queue occupancy
//   Full       Count == DEPTH
//   Empty      Count == 0
module fetch_queue_top #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_fetch,
  output logic [WIDTH-1:0]           PCF,
  input  logic [WIDTH-1:0]           InstrF,
  input  logic                       RedirectE,
  input  logic [WIDTH-1:0]           TargetE,
  output logic [WIDTH-1:0]           InstrD,
  output logic [WIDTH-1:0]           PCD,
  output logic [WIDTH-1:0]           PCPlus4D,
  output logic                       ValidD,
  input  logic                       ReadyD,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Full,
  output logic                       Empty
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_q_instr [DEPTH];
  logic [WIDTH-1:0] r_q_pc    [DEPTH];
  logic [WIDTH-1:0] r_q_pcp4  [DEPTH];

  logic [WIDTH-1:0] r_pc;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  // Last popped entry, shown on PCD/PCPlus4D while the queue is empty. The
  // slot at the read pointer is not usable for this after a flush.
  logic [WIDTH-1:0] r_last_pc;
  logic [WIDTH-1:0] r_last_pcp4;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [WIDTH-1:0] w_pc_plus4;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_pop      = ~w_empty & ReadyD;
  // When full, a simultaneous pop frees the slot on this same edge.
  assign w_push     = en_fetch & ~RedirectE & (~w_full | w_pop);
  assign w_pc_plus4 = r_pc + WIDTH'(4);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc        <= RESET_PC;
      r_count     <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_last_pc   <= '0;
      r_last_pcp4 <= '0;
    end else if (RedirectE) begin
      // Flush wins over any push or pop in the same cycle.
      r_pc    <= {TargetE[WIDTH-1:2], 2'b00};
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
        r_pc   <= w_pc_plus4;
      end
      if (w_pop) begin
        r_rptr      <= r_rptr + PW'(1);
        r_last_pc   <= r_q_pc[r_rptr];
        r_last_pcp4 <= r_q_pcp4[r_rptr];
      end
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wptr] <= InstrF;
      r_q_pc[r_wptr]    <= r_pc;
      r_q_pcp4[r_wptr]  <= w_pc_plus4;
    end
  end

  assign PCF      = r_pc;
  assign Count    = r_count;
  assign Full     = w_full;
  assign Empty    = w_empty;
  assign ValidD   = ~w_empty;
  assign InstrD   = w_empty ? NOP_INSTR   : r_q_instr[r_rptr];
  assign PCD      = w_empty ? r_last_pc   : r_q_pc[r_rptr];
  assign PCPlus4D = w_empty ? r_last_pcp4 : r_q_pcp4[r_rptr];

endmodule

// File: tb/tb_fetch_queue_top.sv
// tb_fetch_queue_top
//   Directed bench for fetch_queue_top (WIDTH=32, DEPTH=4). Instruction memory
//   is modelled as InstrF = PCF ^ 32'h0010_0093 so every entry is distinct.
module tb_fetch_queue_top;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_fetch = 1'b0;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic        RedirectE = 1'b0;
  logic [31:0] TargetE = '0;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        ReadyD = 1'b0;
  logic [2:0]  Count;
  logic        Full;
  logic        Empty;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign InstrF = PCF ^ 32'h0010_0093;

  fetch_queue_top #(
    .WIDTH(32), .DEPTH(4), .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .rst(rst), .en_fetch(en_fetch), .PCF(PCF), .InstrF(InstrF),
    .RedirectE(RedirectE), .TargetE(TargetE), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD), .ReadyD(ReadyD), .Count(Count),
    .Full(Full), .Empty(Empty)
  );

  function automatic logic [31:0] rom(input logic [31:0] pc);
    return pc ^ 32'h0010_0093;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; en_fetch = 1'b0; ReadyD = 1'b0; RedirectE = 1'b0; TargetE = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] pcf, input logic valid,
                           input logic [31:0] pcd, input logic [31:0] pcp4,
                           input logic [2:0] cnt, input logic full);
    chk({tag, ".PCF"}, PCF, pcf);
    chk({tag, ".ValidD"}, {31'b0, ValidD}, {31'b0, valid});
    chk({tag, ".Empty"}, {31'b0, Empty}, {31'b0, ~valid});
    chk({tag, ".Count"}, {29'b0, Count}, {29'b0, cnt});
    chk({tag, ".Full"}, {31'b0, Full}, {31'b0, full});
    chk({tag, ".PCD"}, PCD, pcd);
    chk({tag, ".PCPlus4D"}, PCPlus4D, pcp4);
    chk({tag, ".InstrD"}, InstrD, valid ? rom(pcd) : NOP);
  endtask

  typedef struct {
    logic        en;
    logic        rdy;
    logic [31:0] e_pcf;
    logic        e_valid;
    logic [31:0] e_pcd;
    logic [2:0]  e_cnt;
    logic        e_full;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Scenario A: streaming with ReadyD=1 (rows 0..2).
    vecs.push_back('{1'b1, 1'b1, 32'h04, 1'b1, 32'h00, 3'd1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h08, 1'b1, 32'h04, 3'd1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h0C, 1'b1, 32'h08, 3'd1, 1'b0});
    // Scenario B (after reset): stall 6, full throughput, drain (rows 3..17).
    vecs.push_back('{1'b1, 1'b0, 32'h04, 1'b1, 32'h00, 3'd1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h08, 1'b1, 32'h00, 3'd2, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0C, 1'b1, 32'h00, 3'd3, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h10, 1'b1, 32'h00, 3'd4, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h10, 1'b1, 32'h00, 3'd4, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h10, 1'b1, 32'h00, 3'd4, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 32'h14, 1'b1, 32'h04, 3'd4, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 32'h18, 1'b1, 32'h08, 3'd4, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 32'h1C, 1'b1, 32'h0C, 3'd4, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 32'h20, 1'b1, 32'h10, 3'd4, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 32'h24, 1'b1, 32'h14, 3'd4, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 32'h24, 1'b1, 32'h18, 3'd3, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h24, 1'b1, 32'h1C, 3'd2, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h24, 1'b1, 32'h20, 3'd1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h24, 1'b0, 32'h20, 3'd0, 1'b0});

    do_reset();
    chk_state("reset", 32'h0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 3) begin
        do_reset();
        chk_state("reset2", 32'h0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
      end
      en_fetch = vecs[i].en;
      ReadyD   = vecs[i].rdy;
      step();
      chk_state($sformatf("vec%0d", i), vecs[i].e_pcf, vecs[i].e_valid,
                vecs[i].e_pcd, vecs[i].e_pcd + 32'd4, vecs[i].e_cnt, vecs[i].e_full);
    end

    // Redirect with Count = 3, ReadyD low.
    do_reset();
    en_fetch = 1'b1; ReadyD = 1'b0;
    repeat (3) step();
    chk_state("pre_redir", 32'h0C, 1'b1, 32'h0, 32'h4, 3'd3, 1'b0);
    RedirectE = 1'b1; TargetE = 32'h0000_0102;
    step();
    chk_state("redir1", 32'h100, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    RedirectE = 1'b0;
    step();
    chk_state("redir1_tgt", 32'h104, 1'b1, 32'h100, 32'h104, 3'd1, 1'b0);

    // Redirect with ReadyD high: head discarded, last-popped unchanged.
    ReadyD = 1'b1; RedirectE = 1'b1; TargetE = 32'hFFFF_FFFA;
    step();
    chk_state("redir2", 32'hFFFF_FFF8, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);

    // PC wrap: three pushes then drain.
    RedirectE = 1'b0; ReadyD = 1'b0;
    step();
    chk_state("wrap1", 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 3'd1, 1'b0);
    step();
    chk_state("wrap2", 32'h0, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 3'd2, 1'b0);
    step();
    chk_state("wrap3", 32'h4, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 3'd3, 1'b0);
    en_fetch = 1'b0; ReadyD = 1'b1;
    step();
    chk_state("wrap_pop1", 32'h4, 1'b1, 32'hFFFF_FFFC, 32'h0, 3'd2, 1'b0);
    step();
    chk_state("wrap_pop2", 32'h4, 1'b1, 32'h0, 32'h4, 3'd1, 1'b0);
    step();
    chk_state("wrap_pop3", 32'h4, 1'b0, 32'h0, 32'h4, 3'd0, 1'b0);

    // Asynchronous reset mid-stream with Count = 2, PCF = 0x40.
    en_fetch = 1'b1; ReadyD = 1'b0; RedirectE = 1'b1; TargetE = 32'h38;
    step();
    RedirectE = 1'b0;
    repeat (2) step();
    chk_state("pre_arst", 32'h40, 1'b1, 32'h38, 32'h3C, 3'd2, 1'b0);
    #2 rst = 1'b0;
    #1 chk_state("arst", 32'h0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1; en_fetch = 1'b1; ReadyD = 1'b1;
    step();
    chk_state("arst_restart", 32'h4, 1'b1, 32'h0, 32'h4, 3'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
